// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and frame shape constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with occupancy count; the head entry is visible combinationally.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/out_port_uart_tx.sv
// Out-port console: queues each out-port store and drains the queue as 8N1 frames on tx.
module out_port_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_strobe,
    input  logic [7:0]       data_in,
    input  logic             ovf_clear,
    output logic             tx,
    output logic             busy,
    output logic             fifo_full,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t          state, state_d;
    logic [BAUD_W-1:0]    baud, baud_d;
    logic [2:0]           bit_idx, bit_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic                 tx_d;
    logic                 baud_done;
    logic                 push, pop, drop;
    logic                 full, empty;
    logic [DATA_BITS-1:0] head;
    logic [CNT_W-1:0]     count;

    byte_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .din    (data_in),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // A pop frees a slot on the same edge, so a write to a full FIFO still lands then.
    assign push = wr_strobe && (!full || pop);
    assign drop = wr_strobe && full && !pop;

    assign baud_done = (baud == BAUD_LAST);

    always_comb begin
        state_d = state;
        baud_d  = baud;
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next state so it changes on the same edge as the FSM.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_d;
            shift   <= shift_d;
            tx      <= tx_d;
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign fifo_full  = full;
    assign fifo_count = count;

endmodule
